// File: rtl/sdfm_int_pkg.sv
// Shared constants for the sigma-delta interrupt controller: flag slot map and MIF state encoding.
// No logic, so no latency and no backpressure.
// Slot 7 of each channel is reserved and masked off in every flag register.
package sdfm_int_pkg;
    localparam int NSRC      = 8;
    localparam int SRC_ERR   = 0;
    localparam int SRC_DRDY  = 1;
    localparam int SRC_OVR   = 2;
    localparam int SRC_CLO   = 3;
    localparam int SRC_CHI   = 4;
    localparam int SRC_FLVL  = 5;
    localparam int SRC_FFULL = 6;

    localparam logic [NSRC-1:0] FLG_MASK = 8'h7F;

    typedef enum logic {
        MIF_IDLE  = 1'b0,
        MIF_ARMED = 1'b1
    } mif_state_t;
endpackage

// File: rtl/sdfm_int_src.sv
// One channel's rising-edge detectors, sticky flags and data-ready overrun detection.
// Latency: input edge in cycle N gives flg=1 in cycle N+1.
// No backpressure; set events always win over a coincident clear.
module sdfm_int_src
    import sdfm_int_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            detect_err,
    input  logic            filt_data_update,
    input  logic            comp_data_low,
    input  logic            comp_data_high,
    input  logic            fifo_lvlup,
    input  logic            fifo_full,
    input  logic            filtask,
    input  logic [NSRC-1:0] clr,
    output logic [NSRC-1:0] flg
);
    logic [NSRC-1:0] src;
    logic [NSRC-1:0] prev;
    logic [NSRC-1:0] set_evt;

    always_comb begin
        src            = '0;
        src[SRC_ERR]   = detect_err;
        src[SRC_DRDY]  = filt_data_update;
        src[SRC_CLO]   = comp_data_low;
        src[SRC_CHI]   = comp_data_high;
        src[SRC_FLVL]  = fifo_lvlup;
        src[SRC_FFULL] = fifo_full;
    end

    // Overrun: a new data update arrives while the previous one is still unacknowledged.
    always_comb begin
        set_evt          = src & ~prev;
        set_evt[SRC_OVR] = set_evt[SRC_DRDY] & flg[SRC_DRDY] & ~clr[SRC_DRDY] & filtask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= '0;
            flg  <= '0;
        end else begin
            prev <= src;
            flg  <= (set_evt | (flg & ~clr)) & FLG_MASK;
        end
    end
endmodule

// File: rtl/sdfm_intctl.sv
// Collects per-channel sigma-delta status into sticky flags and drives the master interrupt flag.
// Latency: flg at N+1 after an input edge, mif/irq at N+2; irq is a 1-cycle pulse.
// No backpressure; software acknowledges via flg_clr and mif_clr write-one-to-clear pulses.
module sdfm_intctl
    import sdfm_int_pkg::*;
#(
    parameter int NCH = 4
) (
    input  logic                SYSCLK,
    input  logic                SYSRST,
    input  logic [NCH-1:0]      detect_err,
    input  logic [NCH-1:0]      filt_data_update,
    input  logic [NCH-1:0]      comp_data_low,
    input  logic [NCH-1:0]      comp_data_high,
    input  logic [NCH-1:0]      fifo_lvlup,
    input  logic [NCH-1:0]      fifo_full,
    input  logic [NCH-1:0]      reg_filtask,
    input  logic [NCH*NSRC-1:0] reg_ien,
    input  logic                reg_mie,
    input  logic [NCH*NSRC-1:0] flg_clr,
    input  logic                mif_clr,
    output logic [NCH*NSRC-1:0] flg,
    output logic                mif,
    output logic                irq
);
    mif_state_t state;
    logic       pending;

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        sdfm_int_src u_src (
            .clk              (SYSCLK),
            .rst              (SYSRST),
            .detect_err       (detect_err[ch]),
            .filt_data_update (filt_data_update[ch]),
            .comp_data_low    (comp_data_low[ch]),
            .comp_data_high   (comp_data_high[ch]),
            .fifo_lvlup       (fifo_lvlup[ch]),
            .fifo_full        (fifo_full[ch]),
            .filtask          (reg_filtask[ch]),
            .clr              (flg_clr[ch*NSRC +: NSRC]),
            .flg              (flg[ch*NSRC +: NSRC])
        );
    end

    assign pending = reg_mie & (|(flg & reg_ien));

    // Once armed, further flags accumulate silently until software acknowledges with mif_clr.
    always_ff @(posedge SYSCLK) begin
        if (SYSRST) begin
            state <= MIF_IDLE;
            mif   <= 1'b0;
            irq   <= 1'b0;
        end else begin
            case (state)
                MIF_IDLE: begin
                    if (pending) begin
                        state <= MIF_ARMED;
                        mif   <= 1'b1;
                        irq   <= 1'b1;
                    end else begin
                        irq   <= 1'b0;
                    end
                end
                MIF_ARMED: begin
                    irq <= 1'b0;
                    if (mif_clr) begin
                        state <= MIF_IDLE;
                        mif   <= 1'b0;
                    end
                end
                default: begin
                    state <= MIF_IDLE;
                    mif   <= 1'b0;
                    irq   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sdfm_intctl.sv
// Directed and randomized checks of sdfm_intctl against a cycle-level behavioural model.
module tb_sdfm_intctl;
    localparam int NCH = 4;
    localparam int NF  = NCH * 8;

    logic          SYSCLK = 1'b0;
    logic          SYSRST = 1'b1;
    logic [NCH-1:0] detect_err = '0, filt_data_update = '0, comp_data_low = '0;
    logic [NCH-1:0] comp_data_high = '0, fifo_lvlup = '0, fifo_full = '0, reg_filtask = '0;
    logic [NF-1:0]  reg_ien = '0, flg_clr = '0;
    logic           reg_mie = 1'b0, mif_clr = 1'b0;
    logic [NF-1:0]  flg;
    logic           mif, irq;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [NF-1:0] m_prev = '0;
    logic [NF-1:0] m_flg  = '0;
    logic          m_mif  = 1'b0;
    logic          m_irq  = 1'b0;

    always #5 SYSCLK = ~SYSCLK;

    sdfm_intctl #(.NCH(NCH)) dut (
        .SYSCLK(SYSCLK), .SYSRST(SYSRST),
        .detect_err(detect_err), .filt_data_update(filt_data_update),
        .comp_data_low(comp_data_low), .comp_data_high(comp_data_high),
        .fifo_lvlup(fifo_lvlup), .fifo_full(fifo_full),
        .reg_filtask(reg_filtask), .reg_ien(reg_ien), .reg_mie(reg_mie),
        .flg_clr(flg_clr), .mif_clr(mif_clr),
        .flg(flg), .mif(mif), .irq(irq)
    );

    function automatic logic src_in(int ch, int s);
        case (s)
            0:       return detect_err[ch];
            1:       return filt_data_update[ch];
            3:       return comp_data_low[ch];
            4:       return comp_data_high[ch];
            5:       return fifo_lvlup[ch];
            6:       return fifo_full[ch];
            default: return 1'b0;
        endcase
    endfunction

    // Advance model and DUT by one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        logic [NF-1:0] n_flg, n_prev;
        logic pend, rose, v;
        pend   = reg_mie && ((m_flg & reg_ien) != '0);
        n_flg  = '0;
        n_prev = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            for (int s = 0; s < 8; s++) begin
                v    = src_in(ch, s);
                rose = v && !m_prev[ch*8+s];
                n_prev[ch*8+s] = v;
                if (s == 2)
                    rose = v || (m_flg[ch*8+1] === 1'b1 && src_in(ch, 1) && !m_prev[ch*8+1]
                                 && !flg_clr[ch*8+1] && reg_filtask[ch]);
                if (s != 7)
                    n_flg[ch*8+s] = rose || (m_flg[ch*8+s] && !flg_clr[ch*8+s]);
            end
        end
        if (SYSRST) begin
            m_prev = '0; m_flg = '0; m_mif = 1'b0; m_irq = 1'b0;
        end else begin
            m_irq = !m_mif && pend;
            if (!m_mif && pend) m_mif = 1'b1;
            else if (m_mif && mif_clr) m_mif = 1'b0;
            m_prev = n_prev;
            m_flg  = n_flg;
        end
        @(posedge SYSCLK);
        #1;
    endtask

    task automatic clear_all();
        flg_clr = '1; mif_clr = 1'b1;
        tick();
        flg_clr = '0; mif_clr = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        SYSRST = 1'b1;
        tick(); tick();
        checks++; if (flg !== '0)  begin errors++; $display("FAIL reset_flg: got %h want 0", flg); end
        checks++; if (mif !== 1'b0) begin errors++; $display("FAIL reset_mif: got %b want 0", mif); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
        SYSRST = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_drdy_latency();
        reg_ien = '0; reg_ien[1] = 1'b1; reg_mie = 1'b1;
        filt_data_update[0] = 1'b1;
        tick();
        filt_data_update[0] = 1'b0;
        checks++; if (flg[1] !== 1'b1) begin errors++; $display("FAIL drdy_flg_n1: got %b want 1", flg[1]); end
        checks++; if (mif !== 1'b0) begin errors++; $display("FAIL drdy_mif_n1: got %b want 0", mif); end
        tick();
        checks++; if (mif !== 1'b1) begin errors++; $display("FAIL drdy_mif_n2: got %b want 1", mif); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL drdy_irq_n2: got %b want 1", irq); end
        tick();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL drdy_irq_n3: got %b want 0", irq); end
        clear_all();
        checks++; if (mif !== 1'b0) begin errors++; $display("FAIL drdy_mif_clr: got %b want 0", mif); end
    endtask

    task automatic test_level_once();
        reg_ien = '0;
        comp_data_high[2] = 1'b1;
        tick();
        checks++; if (flg[20] !== 1'b1) begin errors++; $display("FAIL level_set: got %b want 1", flg[20]); end
        repeat (4) tick();
        flg_clr[20] = 1'b1;
        tick();
        flg_clr = '0;
        checks++; if (flg[20] !== 1'b0) begin errors++; $display("FAIL level_clr: got %b want 0", flg[20]); end
        repeat (14) tick();
        checks++; if (flg[20] !== 1'b0) begin errors++; $display("FAIL level_noreset: got %b want 0", flg[20]); end
        comp_data_high = '0;
        tick();
    endtask

    task automatic test_overrun();
        clear_all();
        reg_ien = '0; reg_filtask = 4'b0010;
        filt_data_update[1] = 1'b1; tick(); filt_data_update[1] = 1'b0;
        repeat (4) tick();
        filt_data_update[1] = 1'b1; tick(); filt_data_update[1] = 1'b0;
        checks++; if (flg[9] !== 1'b1)  begin errors++; $display("FAIL ovr_drdy: got %b want 1", flg[9]); end
        checks++; if (flg[10] !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", flg[10]); end
        clear_all();
        filt_data_update[1] = 1'b1; tick(); filt_data_update[1] = 1'b0;
        repeat (4) tick();
        filt_data_update[1] = 1'b1; flg_clr[9] = 1'b1;
        tick();
        filt_data_update[1] = 1'b0; flg_clr = '0;
        checks++; if (flg[10] !== 1'b0) begin errors++; $display("FAIL ovr_acked: got %b want 0", flg[10]); end
        checks++; if (flg[9] !== 1'b1)  begin errors++; $display("FAIL ovr_drdy_keep: got %b want 1", flg[9]); end
        clear_all();
        reg_filtask = '0;
    endtask

    task automatic test_mif_rearm();
        clear_all();
        reg_ien = 32'h18; reg_mie = 1'b1;
        comp_data_low[0] = 1'b1; comp_data_high[0] = 1'b1;
        tick(); tick();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rearm_irq1: got %b want 1", irq); end
        tick();
        mif_clr = 1'b1; tick(); mif_clr = 1'b0;
        checks++; if (mif !== 1'b0) begin errors++; $display("FAIL rearm_mif_drop: got %b want 0", mif); end
        tick();
        checks++; if (mif !== 1'b1) begin errors++; $display("FAIL rearm_mif_back: got %b want 1", mif); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rearm_irq2: got %b want 1", irq); end
        flg_clr = 32'h18; tick(); flg_clr = '0;
        mif_clr = 1'b1; tick(); mif_clr = 1'b0;
        checks++; if (mif !== 1'b0) begin errors++; $display("FAIL rearm_final_mif: got %b want 0", mif); end
        tick();
        checks++; if ({mif, irq} !== 2'b00) begin errors++; $display("FAIL rearm_quiet: got %b want 00", {mif, irq}); end
        comp_data_low = '0; comp_data_high = '0;
        tick();
    endtask

    task automatic test_collide_and_late_ien();
        clear_all();
        reg_ien = '0; reg_mie = 1'b1;
        fifo_lvlup[3] = 1'b1; flg_clr[29] = 1'b1;
        tick();
        flg_clr = '0;
        checks++; if (flg[29] !== 1'b1) begin errors++; $display("FAIL collide_set_wins: got %b want 1", flg[29]); end
        fifo_full[1] = 1'b1;
        tick();
        checks++; if (flg[14] !== 1'b1) begin errors++; $display("FAIL ffull_set: got %b want 1", flg[14]); end
        tick();
        checks++; if (mif !== 1'b0) begin errors++; $display("FAIL ffull_masked: got %b want 0", mif); end
        reg_ien[14] = 1'b1;
        tick();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL late_ien_irq: got %b want 1", irq); end
    endtask

    task automatic test_reset_mid();
        SYSRST = 1'b1;
        tick();
        SYSRST = 1'b0;
        checks++; if (flg !== '0)  begin errors++; $display("FAIL midrst_flg: got %h want 0", flg); end
        checks++; if ({mif, irq} !== 2'b00) begin errors++; $display("FAIL midrst_mif_irq: got %b want 00", {mif, irq}); end
        tick();
        checks++; if ({flg[29], flg[14]} !== 2'b11) begin errors++; $display("FAIL midrst_held_reset: got %b want 11", {flg[29], flg[14]}); end
        tick();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL midrst_irq: got %b want 1", irq); end
        fifo_lvlup = '0; fifo_full = '0;
        clear_all();
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if (i % 60 == 0) begin
                reg_ien     = $urandom;
                reg_filtask = 4'($urandom);
                reg_mie     = ($urandom_range(0, 3) != 0);
            end
            detect_err       = 4'($urandom) & 4'($urandom);
            filt_data_update = 4'($urandom);
            comp_data_low    = 4'($urandom);
            comp_data_high   = 4'($urandom);
            fifo_lvlup       = 4'($urandom) & 4'($urandom);
            fifo_full        = 4'($urandom) & 4'($urandom);
            flg_clr          = $urandom & $urandom & $urandom;
            mif_clr          = ($urandom_range(0, 3) == 0);
            SYSRST           = ($urandom_range(0, 149) == 0);
            tick();
            checks++; if (flg !== m_flg) begin errors++; $display("FAIL rnd_flg[%0d]: got %h want %h", i, flg, m_flg); end
            checks++; if (mif !== m_mif) begin errors++; $display("FAIL rnd_mif[%0d]: got %b want %b", i, mif, m_mif); end
            checks++; if (irq !== m_irq) begin errors++; $display("FAIL rnd_irq[%0d]: got %b want %b", i, irq, m_irq); end
            checks++;
            if ((flg & 32'h8080_8080) !== '0) begin
                errors++; $display("FAIL rnd_slot7[%0d]: got %h want 0", i, flg & 32'h8080_8080);
            end
        end
        SYSRST = 1'b0;
    endtask

    initial begin
        test_reset();
        test_drdy_latency();
        test_level_once();
        test_overrun();
        test_mif_rearm();
        test_collide_and_late_ien();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sdfm_intctl.md
# sdfm_intctl

Interrupt and flag controller sitting directly downstream of the sigma-delta channel blocks. It collects the per-channel status outputs: clock-detect error, filter data update, comparator low/high, FIFO level-up and FIFO full. It latches them into sticky, software-clearable flags, detects data-ready overrun, and produces one master interrupt with acknowledge semantics (master interrupt flag, MIF). It is the single interrupt source the register/bus interface exposes to the CPU.

## Interface
Parameters:
- NCH, 4, number of channels served.
- NSRC, 8, flag slots per channel (fixed by package; slot 7 reserved, reads 0).

Ports:
- SYSCLK  in  1  system clock; the only clock.
- SYSRST  in  1  reset; synchronous, active-high.
- detect_err  in  NCH  per-channel clock-detect error (level).
- filt_data_update  in  NCH  per-channel filter data update (1-cycle pulse).
- comp_data_low  in  NCH  comparator below low threshold (level).
- comp_data_high  in  NCH  comparator at/above high threshold (level).
- fifo_lvlup  in  NCH  FIFO reached interrupt level (level).
- fifo_full  in  NCH  FIFO full (level).
- reg_filtask  in  NCH  data-ready acknowledge mode enable (enables overrun detection).
- reg_ien  in  NCH*NSRC  per-flag interrupt enable.
- reg_mie  in  1  master interrupt enable.
- flg_clr  in  NCH*NSRC  write-one-to-clear pulses for flags.
- mif_clr  in  1  write-one-to-clear pulse for MIF.
- flg  out  NCH*NSRC  sticky flags.
- mif  out  1  master interrupt flag.
- irq  out  1  interrupt request, 1-cycle pulse.

## Operation
- Flag slot index = ch*NSRC + s, where s is one of: 0 ERR, 1 DRDY, 2 OVR, 3 CLO, 4 CHI, 5 FLVL, 6 FFULL, 7 reserved.
- Edge detection:
  - Each source input, except OVR which is derived, is registered once (prev, reset 0).
  - A set event is input & ~prev, i.e. a rising edge.
  - Pulses and levels are treated identically, so a held level sets its flag once.
- Overrun: OVR[ch] sets when all three hold in the same cycle:
  - filt_data_update[ch] set event;
  - DRDY[ch] flag = 1 and flg_clr of DRDY[ch] = 0;
  - reg_filtask[ch] = 1.
- DRDY stays set on overrun.
- Flag update, per bit: flg <= set_event | (flg & ~flg_clr). A set and a clear in the same cycle leave the flag at 1; no event is lost.
- Reserved slot 7 is constant 0 and ignores set and clear.
- pending = reg_mie & |(flg & reg_ien).
- MIF/IRQ state machine:
  - IDLE (mif=0): if pending, go to ARMED, mif<=1, irq<=1 for one cycle.
  - ARMED (mif=1): irq=0; flags keep accumulating and no further irq is issued. mif_clr returns to IDLE.
  - If pending is still true after mif_clr, a new irq fires on the following evaluation, so remaining enabled flags re-interrupt.
- mif_clr while in IDLE has no effect.
- Disabling reg_ien or reg_mie never clears flags or MIF.

## Timing
- Reset values: flg=0, mif=0, irq=0, prev=0.
- An input already high at reset release sets its flag on the first cycle after SYSRST deasserts.
- Latency:
  - Input rising at cycle N: edge seen at N, flg=1 at N+1.
  - mif=1 and irq pulse at N+2 (pending is evaluated on the registered flg).
- flg_clr asserted at N: flag reads 0 at N+1.
- mif_clr asserted at N: mif=0 at N+1. If pending at N+1, then mif=1 and irq=1 at N+2.
- Minimum irq spacing is 2 cycles.
- SYSRST asserted mid-operation: all state returns to reset values on the next edge. No irq is produced in the cycle reset is sampled.

## Structure
- Package sdfm_int_pkg holds:
  - NSRC=8;
  - slot constants SRC_ERR=0, SRC_DRDY=1, SRC_OVR=2, SRC_CLO=3, SRC_CHI=4, SRC_FLVL=5, SRC_FFULL=6;
  - the MIF state encoding (IDLE, ARMED).
- Sub-module sdfm_int_src: one channel's edge detectors, 8 flags and overrun logic; instantiated NCH times via generate.
- Top level: pending reduction and the MIF state machine.

## Test plan
- Reset, then pulse filt_data_update[0] at cycle 10 with reg_ien[1]=1 and reg_mie=1: flg[1]=1 at 11; mif=1 and a single irq pulse at 12.
- Hold comp_data_high[2] high for 20 cycles: flg[2*8+4] sets exactly once; clear at cycle 15 while the level is still high: stays 0, no re-set.
- reg_filtask[1]=1, two filt_data_update[1] pulses 5 cycles apart, no clear: flg[9]=1 and flg[10]=1. Repeat with flg_clr[9] coincident with the second pulse: OVR stays 0, DRDY=1.
- Two enabled flags set, mif_clr once: mif drops for 1 cycle, then a second irq. Clear both flags, then mif_clr: mif stays 0, no irq.
- flg_clr and set event on the same bit in the same cycle: flag=1. Set fifo_full with reg_ien=0: flag=1, mif=0; set reg_ien: irq 1 cycle later.
- Assert SYSRST mid-ARMED with flags set: flg=0, mif=0, irq=0 next cycle; slot 7 never reads 1 under any clr/set pattern.
